// File: rtl/bscac_pkg.sv
// Shared constants and helpers for the BSCAC Hex7 segment path.
package bscac_pkg;

    localparam int unsigned BSCAC_NUM_SEG = 3;
    localparam int unsigned BSCAC_SEG_W   = 7;

    localparam logic [2:0] PH0 = 3'b001;
    localparam logic [2:0] PH1 = 3'b010;
    localparam logic [2:0] PH2 = 3'b100;

    function automatic logic is_onehot3(input logic [2:0] flags);
        return (flags == PH0) || (flags == PH1) || (flags == PH2);
    endfunction

endpackage

// File: rtl/bscac_seg_sel.sv
// Combinational segment selector: one-hot phase + word -> segment, index, last, legal.
module bscac_seg_sel
    import bscac_pkg::*;
#(
    parameter int unsigned SEG_W   = BSCAC_SEG_W,
    parameter int unsigned NUM_SEG = BSCAC_NUM_SEG
) (
    input  logic [2:0]               phase,
    input  logic [NUM_SEG*SEG_W-1:0] word,
    output logic [SEG_W-1:0]         seg,
    output logic [1:0]               idx,
    output logic                     last,
    output logic                     legal
);

    always_comb begin
        seg   = '0;
        idx   = 2'd0;
        last  = 1'b0;
        legal = is_onehot3(phase);
        case (phase)
            PH0: seg = word[0 +: SEG_W];
            PH1: begin
                seg = word[SEG_W +: SEG_W];
                idx = 2'd1;
            end
            PH2: begin
                seg  = word[2*SEG_W +: SEG_W];
                idx  = 2'd2;
                last = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bscac_seg_mux.sv
// Word-to-segment serializer driven by the 3-phase ring controller (pend + act buffers).
// Optional illegal-phase checking is built when BSCAC_ONEHOT_CHECK_EN is defined.
module bscac_seg_mux
    import bscac_pkg::*;
#(
    parameter int unsigned SEG_W     = BSCAC_SEG_W,
    parameter int unsigned NUM_SEG   = BSCAC_NUM_SEG,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               ctrl_flags,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SEG*SEG_W-1:0] in_data,
    output logic                     out_valid,
    output logic [SEG_W-1:0]         out_data,
    output logic [1:0]               out_seg_idx,
    output logic                     out_last,
    output logic                     err_onehot,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    logic [NUM_SEG*SEG_W-1:0] pend_word, act_word, sel_word;
    logic                     pend_vld, act_vld;
    logic                     is_ph0, is_ph2, accept, emit;
    logic [SEG_W-1:0]         sel_seg;
    logic [1:0]               sel_idx;
    logic                     sel_last, sel_legal;

    assign is_ph0   = (ctrl_flags == PH0);
    assign is_ph2   = (ctrl_flags == PH2);
    assign in_ready = ~pend_vld | is_ph0;
    assign accept   = in_valid & in_ready;

    // At phase 0 the word being started is pend if present, else the incoming bypass word.
    assign sel_word = is_ph0 ? (pend_vld ? pend_word : in_data) : act_word;
    assign emit     = sel_legal & (is_ph0 ? (pend_vld | accept) : act_vld);

    bscac_seg_sel #(
        .SEG_W  (SEG_W),
        .NUM_SEG(NUM_SEG)
    ) u_seg_sel (
        .phase(ctrl_flags),
        .word (sel_word),
        .seg  (sel_seg),
        .idx  (sel_idx),
        .last (sel_last),
        .legal(sel_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_word   <= '0;
            act_word    <= '0;
            pend_vld    <= 1'b0;
            act_vld     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_seg_idx <= 2'd0;
            out_last    <= 1'b0;
        end else begin
            if (is_ph0) begin
                if (pend_vld) begin
                    act_word <= pend_word;
                    act_vld  <= 1'b1;
                    pend_vld <= accept;
                    if (accept) pend_word <= in_data;
                end else if (accept) begin
                    act_word <= in_data;
                    act_vld  <= 1'b1;
                end else begin
                    act_vld <= 1'b0;
                end
            end else begin
                // Outside phase 0 accept only happens into an empty pend slot.
                if (accept) begin
                    pend_word <= in_data;
                    pend_vld  <= 1'b1;
                end
                if (is_ph2) act_vld <= 1'b0;
            end

            if (emit) begin
                out_valid   <= 1'b1;
                out_data    <= sel_seg;
                out_seg_idx <= sel_idx;
                out_last    <= sel_last;
            end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef BSCAC_ONEHOT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_onehot <= 1'b0;
            err_cnt    <= '0;
        end else if (!sel_legal) begin
            err_onehot <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`else
    assign err_onehot = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule
